// File: rtl/sequencer_pkg.sv
// Shared types for the suro-v.2 control path: opcodes, source selects, the
// datapath control bundle and the sequencer state encoding.
package sequencer_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_FENCE  = 7'h0F,
    OPC_OP_IMM = 7'h13,
    OPC_AUIPC  = 7'h17,
    OPC_STORE  = 7'h23,
    OPC_OP     = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6F,
    OPC_SYSTEM = 7'h73
  } opcode_t;

  typedef enum logic [2:0] {
    SRC_PC_PLUS4 = 3'd0,
    SRC_PC2      = 3'd1,
    SRC_ALU      = 3'd2,
    SRC_RF       = 3'd3,
    SRC_MEM      = 3'd4,
    SRC_CNTR     = 3'd5
  } src_t;

  typedef enum logic [1:0] {
    REG_RS1 = 2'd0,
    REG_RS2 = 2'd1,
    REG_RD  = 2'd2,
    REG_X0  = 2'd3
  } regsel_t;

  typedef struct packed {
    logic    set_ir;
    logic    ir_src;
    logic    set_pc;
    src_t    pc_src;
    src_t    maddr_src;
    logic    set_r1;
    src_t    r1_src;
    logic    set_r2;
    logic    r2_src;
    regsel_t rf_regnum_src;
    src_t    rf_src;
    logic    start;
    logic    alu_op;
    logic    alu_a_r1;
    logic    alu_b_r2;
    logic    set_pc2;
    logic    memop;
  } ctrl_t;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_READ2  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_TARGET = 3'd4,
    ST_MEM    = 3'd5,
    ST_WB     = 3'd6,
    ST_TRAP   = 3'd7
  } seq_state_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic logic is_legal(input opcode_t op);
    case (op)
      OPC_LOAD, OPC_FENCE, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Only funct3 tells a shift from other ALU ops; the datapath ignores the
  // r2 reload for non-shifts, so any OP/OP-IMM may request it while busy.
  function automatic logic may_shift(input opcode_t op);
    return (op == OPC_OP) || (op == OPC_OP_IMM);
  endfunction

endpackage

// File: rtl/sequencer_if.sv
// Sequencer-to-datapath/memory signal bundle.
interface sequencer_if;
  import sequencer_pkg::*;

  ctrl_t   ctrl;
  logic    done;
  logic    branch_taken;
  logic    forward;
  opcode_t opcode;
  logic    mem_req;
  logic    mem_ready;
  logic    mem_we;
  logic    rf_we;
  logic    retire;
  logic    trap;

  modport master (
    output ctrl, mem_req, mem_we, rf_we, retire, trap,
    input  done, branch_taken, forward, opcode, mem_ready
  );

  modport slave (
    input  ctrl, mem_req, mem_we, rf_we, retire, trap,
    output done, branch_taken, forward, opcode, mem_ready
  );
endinterface

// File: rtl/seq_decode.sv
// Combinational map from (state, opcode, handshakes) to control bundle,
// strobes and next state.
module seq_decode
  import sequencer_pkg::*;
#(
  parameter bit TRAP_EN = 1'b1
) (
  input  seq_state_t state,
  input  logic       entry,
  input  logic       redirect,
  input  opcode_t    opcode,
  input  logic       done,
  input  logic       branch_taken,
  input  logic       forward,
  input  logic       mem_ready,
  output ctrl_t      ctrl,
  output logic       mem_req,
  output logic       mem_we,
  output logic       rf_we,
  output logic       retire,
  output logic       set_redirect,
  output logic       clr_redirect,
  output seq_state_t state_next
);

  always_comb begin
    ctrl         = CTRL_IDLE;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    rf_we        = 1'b0;
    retire       = 1'b0;
    set_redirect = 1'b0;
    clr_redirect = 1'b0;
    state_next   = state;

    case (state)
      ST_FETCH: begin
        mem_req        = 1'b1;
        ctrl.ir_src    = 1'b1;
        ctrl.set_ir    = 1'b1;
        ctrl.maddr_src = redirect ? SRC_PC2 : SRC_PC_PLUS4;
        ctrl.pc_src    = redirect ? SRC_PC2 : SRC_PC_PLUS4;
        if (mem_ready && done) begin
          ctrl.set_pc  = 1'b1;
          clr_redirect = 1'b1;
          state_next   = forward ? ST_EXEC : ST_DECODE;
        end
      end

      ST_DECODE: begin
        ctrl.set_r1        = 1'b1;
        ctrl.r1_src        = SRC_RF;
        ctrl.rf_regnum_src = (opcode == OPC_LUI) ? REG_X0 : REG_RS1;
        if (!is_legal(opcode)) begin
          if (TRAP_EN) begin
            state_next = ST_TRAP;
          end else begin
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
        end else if (opcode inside {OPC_OP, OPC_BRANCH, OPC_STORE}) begin
          state_next = ST_READ2;
        end else begin
          state_next = ST_EXEC;
        end
      end

      ST_READ2: begin
        ctrl.rf_regnum_src = REG_RS2;
        ctrl.set_r2        = 1'b1;
        ctrl.r2_src        = 1'b1;
        state_next         = ST_EXEC;
      end

      ST_EXEC: begin
        ctrl.start    = entry;
        ctrl.alu_op   = 1'b1;
        ctrl.alu_a_r1 = !((opcode == OPC_AUIPC) || (opcode == OPC_JAL));
        ctrl.alu_b_r2 = (opcode == OPC_OP) || (opcode == OPC_BRANCH);
        if (done) begin
          case (opcode)
            OPC_LOAD, OPC_STORE: state_next = ST_MEM;
            OPC_JAL, OPC_JALR: begin
              ctrl.set_pc2 = 1'b1;
              set_redirect = 1'b1;
              state_next   = ST_WB;
            end
            OPC_BRANCH: begin
              if (branch_taken) begin
                state_next = ST_TARGET;
              end else begin
                retire     = 1'b1;
                state_next = ST_FETCH;
              end
            end
            OPC_FENCE: begin
              retire     = 1'b1;
              state_next = ST_FETCH;
            end
            default: state_next = ST_WB;
          endcase
        end else if (may_shift(opcode)) begin
          ctrl.set_r2 = 1'b1;
          ctrl.r2_src = 1'b0;
        end
      end

      ST_TARGET: begin
        ctrl.start = entry;
        if (done) begin
          ctrl.set_pc2 = 1'b1;
          set_redirect = 1'b1;
          retire       = 1'b1;
          state_next   = ST_FETCH;
        end
      end

      ST_MEM: begin
        mem_req        = 1'b1;
        ctrl.memop     = 1'b1;
        ctrl.maddr_src = SRC_ALU;
        mem_we         = (opcode == OPC_STORE);
        if (mem_ready) begin
          if (opcode == OPC_LOAD) begin
            rf_we              = 1'b1;
            ctrl.rf_regnum_src = REG_RD;
            ctrl.rf_src        = SRC_MEM;
          end
          retire     = 1'b1;
          state_next = ST_FETCH;
        end
      end

      ST_WB: begin
        ctrl.rf_regnum_src = REG_RD;
        rf_we              = 1'b1;
        retire             = 1'b1;
        state_next         = ST_FETCH;
        case (opcode)
          OPC_JAL, OPC_JALR: ctrl.rf_src = SRC_PC_PLUS4;
          OPC_SYSTEM:        ctrl.rf_src = SRC_CNTR;
          default:           ctrl.rf_src = SRC_ALU;
        endcase
      end

      ST_TRAP: state_next = ST_TRAP;

      default: state_next = ST_FETCH;
    endcase
  end

endmodule

// File: rtl/sequencer.sv
// Multi-cycle instruction sequencer: state, redirect and trap flops around
// the combinational decode.
module sequencer
  import sequencer_pkg::*;
#(
  parameter bit TRAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  sequencer_if.master bus
);

  seq_state_t state_q, state_next;
  logic       entry_q, redirect_q, trap_q;
  ctrl_t      ctrl_d;
  logic       mem_req_d, mem_we_d, rf_we_d, retire_d;
  logic       set_redirect, clr_redirect;

  seq_decode #(.TRAP_EN(TRAP_EN)) u_decode (
    .state        (state_q),
    .entry        (entry_q),
    .redirect     (redirect_q),
    .opcode       (bus.opcode),
    .done         (bus.done),
    .branch_taken (bus.branch_taken),
    .forward      (bus.forward),
    .mem_ready    (bus.mem_ready),
    .ctrl         (ctrl_d),
    .mem_req      (mem_req_d),
    .mem_we       (mem_we_d),
    .rf_we        (rf_we_d),
    .retire       (retire_d),
    .set_redirect (set_redirect),
    .clr_redirect (clr_redirect),
    .state_next   (state_next)
  );

  // entry_q marks the first cycle in a state so start fires once per ALU op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      entry_q    <= 1'b1;
      redirect_q <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q <= state_next;
      entry_q <= (state_next != state_q);
      if (set_redirect)      redirect_q <= 1'b1;
      else if (clr_redirect) redirect_q <= 1'b0;
      if (state_next == ST_TRAP) trap_q <= 1'b1;
    end
  end

  // Outputs are masked by rst_n so an outstanding request drops the moment
  // reset asserts, not at the next edge.
  assign bus.ctrl    = rst_n ? ctrl_d : CTRL_IDLE;
  assign bus.mem_req = rst_n & mem_req_d;
  assign bus.mem_we  = rst_n & mem_we_d;
  assign bus.rf_we   = rst_n & rf_we_d;
  assign bus.retire  = rst_n & retire_d;
  assign bus.trap    = trap_q;

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for sequencer: walks hand-timed instruction sequences and
// compares every control output against hand-computed values.
module tb_sequencer;
  import sequencer_pkg::*;

  logic clk;
  logic rst_n;
  logic rst_n0;
  int   total = 0;
  int   bad   = 0;
  int   nstart;

  sequencer_if bus ();
  sequencer_if bus0 ();

  sequencer #(.TRAP_EN(1'b1)) u_dut  (.clk(clk), .rst_n(rst_n),  .bus(bus.master));
  sequencer #(.TRAP_EN(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n0), .bus(bus0.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic d, input logic mr, input logic br, input logic fw);
    @(negedge clk);
    bus.done  = d;  bus.mem_ready  = mr; bus.branch_taken  = br; bus.forward  = fw;
    bus0.done = d;  bus0.mem_ready = mr; bus0.branch_taken = br; bus0.forward = fw;
    #1;
  endtask

  task automatic set_op(input opcode_t op);
    bus.opcode  = op;
    bus0.opcode = op;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    rst_n0 = 1'b0;
    set_op(OPC_OP_IMM);
    bus.done = 0;  bus.mem_ready = 0;  bus.branch_taken = 0;  bus.forward = 0;
    bus0.done = 0; bus0.mem_ready = 0; bus0.branch_taken = 0; bus0.forward = 0;

    // reset state
    @(negedge clk); #1;
    check("rst_mem_req", 32'(bus.mem_req), 0);
    check("rst_ctrl",    32'(bus.ctrl), 0);
    check("rst_retire",  32'(bus.retire), 0);
    check("rst_rf_we",   32'(bus.rf_we), 0);
    check("rst_trap",    32'(bus.trap), 0);
    rst_n = 1'b1; #1;
    check("first_req",   32'(bus.mem_req), 1);
    check("first_state", 32'(u_dut.state_q), 32'(ST_FETCH));

    // ADDI, zero-wait, 1-cycle ALU: FETCH DECODE EXEC WB
    drive(1, 1, 0, 0);
    check("addi_c1_setpc", 32'(bus.ctrl.set_pc), 1);
    check("addi_c1_maddr", 32'(bus.ctrl.maddr_src), 32'(SRC_PC_PLUS4));
    drive(1, 0, 0, 0);
    check("addi_c2_state", 32'(u_dut.state_q), 32'(ST_DECODE));
    check("addi_c2_rsel",  32'(bus.ctrl.rf_regnum_src), 32'(REG_RS1));
    drive(1, 0, 0, 0);
    check("addi_c3_state", 32'(u_dut.state_q), 32'(ST_EXEC));
    check("addi_c3_start", 32'(bus.ctrl.start), 1);
    check("addi_c3_ret",   32'(bus.retire), 0);
    drive(1, 0, 0, 0);
    check("addi_c4_ret",   32'(bus.retire), 1);
    check("addi_c4_rfwe",  32'(bus.rf_we), 1);
    check("addi_c4_rfsrc", 32'(bus.ctrl.rf_src), 32'(SRC_ALU));

    // forwarded ADDI: DECODE skipped
    drive(1, 1, 0, 1);
    check("fwd_c1_state", 32'(u_dut.state_q), 32'(ST_FETCH));
    drive(1, 0, 0, 0);
    check("fwd_c2_state", 32'(u_dut.state_q), 32'(ST_EXEC));
    check("fwd_c2_ret",   32'(bus.retire), 0);
    drive(1, 0, 0, 0);
    check("fwd_c3_ret",   32'(bus.retire), 1);

    // LW with 3 wait cycles
    set_op(OPC_LOAD);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    check("lw_exec_state", 32'(u_dut.state_q), 32'(ST_EXEC));
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0);
      check("lw_wait_req",   32'(bus.mem_req), 1);
      check("lw_wait_maddr", 32'(bus.ctrl.maddr_src), 32'(SRC_ALU));
      check("lw_wait_rfwe",  32'(bus.rf_we), 0);
      check("lw_wait_ret",   32'(bus.retire), 0);
    end
    drive(1, 1, 0, 0);
    check("lw_rdy_req",   32'(bus.mem_req), 1);
    check("lw_rdy_rfwe",  32'(bus.rf_we), 1);
    check("lw_rdy_ret",   32'(bus.retire), 1);
    check("lw_rdy_rfsrc", 32'(bus.ctrl.rf_src), 32'(SRC_MEM));

    // SW zero-wait: 5 cycles
    set_op(OPC_STORE);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    check("sw_read2", 32'(u_dut.state_q), 32'(ST_READ2));
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    check("sw_mem_we", 32'(bus.mem_we), 1);
    check("sw_ret",    32'(bus.retire), 1);
    check("sw_rfwe",   32'(bus.rf_we), 0);

    // taken BEQ
    set_op(OPC_BRANCH);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    check("beq_r2src", 32'({bus.ctrl.set_r2, bus.ctrl.r2_src}), 32'h3);
    drive(1, 0, 1, 0);
    check("beq_exec_bsel", 32'(bus.ctrl.alu_b_r2), 1);
    check("beq_exec_ret",  32'(bus.retire), 0);
    drive(1, 0, 1, 0);
    check("beq_tgt_state", 32'(u_dut.state_q), 32'(ST_TARGET));
    check("beq_tgt_pc2",   32'(bus.ctrl.set_pc2), 1);
    check("beq_tgt_start", 32'(bus.ctrl.start), 1);
    check("beq_tgt_ret",   32'(bus.retire), 1);

    // fetch of the branch target, then a not-taken BEQ
    drive(1, 1, 0, 0);
    check("tgt_fetch_maddr", 32'(bus.ctrl.maddr_src), 32'(SRC_PC2));
    check("tgt_fetch_pcsrc", 32'(bus.ctrl.pc_src), 32'(SRC_PC2));
    drive(1, 0, 0, 0);
    check("redirect_clr", 32'(u_dut.redirect_q), 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    check("bne_ret", 32'(bus.retire), 1);

    // next FETCH stalls on mem_ready without done
    set_op(OPC_OP_IMM);
    drive(0, 1, 0, 0);
    check("nt_fetch_maddr", 32'(bus.ctrl.maddr_src), 32'(SRC_PC_PLUS4));
    check("stall_setpc",    32'(bus.ctrl.set_pc), 0);
    drive(1, 1, 0, 0);
    check("stall_hold",     32'(u_dut.state_q), 32'(ST_FETCH));
    check("stall_req",      32'(bus.mem_req), 1);

    // SLLI with a 4-cycle ALU
    drive(1, 0, 0, 0);
    nstart = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      nstart += int'(bus.ctrl.start);
      check("slli_busy_r2", 32'({bus.ctrl.set_r2, bus.ctrl.r2_src}), 32'h2);
      check("slli_busy_st", 32'(u_dut.state_q), 32'(ST_EXEC));
    end
    drive(1, 0, 0, 0);
    nstart += int'(bus.ctrl.start);
    check("slli_done_r2", 32'(bus.ctrl.set_r2), 0);
    check("slli_done_ret", 32'(bus.retire), 0);
    check("slli_nstart",  32'(nstart), 1);
    drive(1, 0, 0, 0);
    check("slli_wb_state", 32'(u_dut.state_q), 32'(ST_WB));
    check("slli_wb_ret",   32'(bus.retire), 1);

    // JAL: link from PC+4, next fetch from pc2
    set_op(OPC_JAL);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    check("jal_asel", 32'(bus.ctrl.alu_a_r1), 0);
    check("jal_pc2",  32'(bus.ctrl.set_pc2), 1);
    drive(1, 0, 0, 0);
    check("jal_rfsrc", 32'(bus.ctrl.rf_src), 32'(SRC_PC_PLUS4));
    set_op(OPC_LOAD);
    drive(0, 0, 0, 0);
    check("jal_fetch_maddr", 32'(bus.ctrl.maddr_src), 32'(SRC_PC2));

    // reset in the middle of a load access
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    check("mrst_pre_req", 32'(bus.mem_req), 1);
    rst_n = 1'b0; #1;
    check("mrst_req_drop", 32'(bus.mem_req), 0);
    check("mrst_ctrl",     32'(bus.ctrl), 0);
    drive(1, 1, 0, 0);
    check("mrst_late_rdy", 32'({bus.mem_req, bus.retire, bus.rf_we}), 0);
    drive(0, 0, 0, 0);
    rst_n = 1'b1; #1;
    check("mrst_state",    32'(u_dut.state_q), 32'(ST_FETCH));
    check("mrst_req",      32'(bus.mem_req), 1);
    check("mrst_redirect", 32'(u_dut.redirect_q), 0);
    check("mrst_maddr",    32'(bus.ctrl.maddr_src), 32'(SRC_PC_PLUS4));

    // illegal opcode with TRAP_EN=1
    set_op(opcode_t'(7'h7F));
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    check("ill_dec_ret", 32'(bus.retire), 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0);
      check("trap_flag", 32'(bus.trap), 1);
      check("trap_req",  32'(bus.mem_req), 0);
      check("trap_ret",  32'(bus.retire), 0);
    end

    // illegal opcode with TRAP_EN=0
    @(posedge clk); #1;
    rst_n0 = 1'b1;
    drive(1, 1, 0, 0);
    check("nt0_fetch_req", 32'(bus0.mem_req), 1);
    drive(1, 0, 0, 0);
    check("nt0_ret",  32'(bus0.retire), 1);
    check("nt0_trap", 32'(bus0.trap), 0);
    drive(0, 0, 0, 0);
    check("nt0_refetch", 32'({bus0.mem_req, bus0.trap}), 32'h2);
    check("trap_sticky", 32'(bus.trap), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
